// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx - UART serial transmitter (16x oversampling, LSB-first)
//
// Serialises one byte per frame: start bit, DBIT data bits, an optional parity
// bit, then the stop period. It uses the same 16x s_tick strobe as uart_rx.
//
// Parameters
//   DBIT     data bits per frame (7 or 8)
//   SB_TICK  s_ticks in the stop period (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//   PARITY   0 = none, 1 = odd, 2 = even
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   s_tick        1-clk strobe at 16x baud
//   tx_start      request to send din
//   din           data byte (only din[DBIT-1:0] is used)
//   tx_ready      1 while idle (the transmitter can accept tx_start)
//   tx_done_tick  1-clk pulse on the final s_tick of the stop period
//   tx            serial line, idle high, registered
//
// Handshake: a transfer happens on the clock edge where tx_start=1 and
// tx_ready=1. din is captured on that edge and not looked at again. While
// tx_ready=0, tx_start is ignored and nothing is queued.
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_ready,
    output logic       tx_done_tick,
    output logic       tx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Keeps only the DBIT data bits of din, so din[7] never reaches the line
    // in a 7-bit configuration.
    localparam logic [7:0] DMASK = 8'((9'd1 << DBIT) - 9'd1);

    state_t     state_reg, state_next;
    logic [4:0] s_reg, s_next;      // s_tick counter within the current bit
    logic [2:0] n_reg, n_next;      // data bit index
    logic [7:0] b_reg, b_next;      // data shift register, bit 0 is on the line
    logic       par_reg, par_next;  // parity bit for the frame in flight
    logic       tx_reg, tx_next;
    logic       data_par;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= 5'd0;
            n_reg     <= 3'd0;
            b_reg     <= 8'd0;
            par_reg   <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            par_reg   <= par_next;
            tx_reg    <= tx_next;
        end
    end

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    assign data_par = ^(din & DMASK);

    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        par_next     = par_reg;
        tx_done_tick = 1'b0;

        case (state_reg)
            IDLE: begin
                // A tick in the accept cycle is not counted toward the start bit.
                if (tx_start) begin
                    state_next = START;
                    s_next     = 5'd0;
                    n_next     = 3'd0;
                    b_next     = din & DMASK;
                    par_next   = (PARITY == 1) ? ~data_par : data_par;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == 5'd15) begin
                        state_next = DATA;
                        s_next     = 5'd0;
                        n_next     = 3'd0;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == 5'd15) begin
                        s_next = 5'd0;
                        b_next = b_reg >> 1;
                        if (n_reg == 3'(DBIT - 1)) begin
                            state_next = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            PAR: begin
                if (s_tick) begin
                    if (s_reg == 5'd15) begin
                        state_next = STOP;
                        s_next     = 5'd0;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == 5'(SB_TICK - 1)) begin
                        state_next   = IDLE;
                        tx_done_tick = 1'b1;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The line level is derived from the next state so that tx is a plain
        // register output and changes exactly on the bit boundaries.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
            PAR:     tx_next = par_next;
            default: tx_next = 1'b1;
        endcase
    end

    assign tx_ready = (state_reg == IDLE);
    assign tx       = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx - self-checking bench for uart_tx
//
// Four transmitters share one s_tick:
//   u0: DBIT=8 SB_TICK=16 no parity
//   u1: DBIT=8 SB_TICK=16 even parity
//   u2: DBIT=8 SB_TICK=16 odd parity
//   u3: DBIT=7 SB_TICK=32 no parity
// The line is sampled on every s_tick cycle from the cycle after accept
// until tx_done_tick. The samples must contain 16 samples per bit and
// SB_TICK samples of stop.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    // ---------------- clock / reset / tick ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       tick_en;
    logic [1:0] div = 2'd0;
    logic       s_tick;

    always @(posedge clk) div <= (div == 2'd2) ? 2'd0 : div + 2'd1;
    assign s_tick = tick_en && (div == 2'd0);

    logic [3:0] tx_start;
    logic [7:0] din [4];
    wire  [3:0] tx;
    wire  [3:0] tx_ready;
    wire  [3:0] tx_done_tick;

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[0]), .din(din[0]),
        .tx_ready(tx_ready[0]), .tx_done_tick(tx_done_tick[0]), .tx(tx[0]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[1]), .din(din[1]),
        .tx_ready(tx_ready[1]), .tx_done_tick(tx_done_tick[1]), .tx(tx[1]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u2 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[2]), .din(din[2]),
        .tx_ready(tx_ready[2]), .tx_done_tick(tx_done_tick[2]), .tx(tx[2]));
    uart_tx #(.DBIT(7), .SB_TICK(32), .PARITY(0)) u3 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[3]), .din(din[3]),
        .tx_ready(tx_ready[3]), .tx_done_tick(tx_done_tick[3]), .tx(tx[3]));

    // ---------------- scoreboard ----------------
    int   checks = 0;
    int   errors = 0;
    logic cap_q [$];
    logic cap_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Pulses tx_start for one clock. Returns at the negedge of the first
    // cycle after accept. With align=1 the accept cycle also carries s_tick.
    task automatic send(input int idx, input logic [7:0] d, input logic align);
        int g;
        @(negedge clk);
        g = 0;
        if (align) begin
            while (!s_tick && g < 10) begin
                @(negedge clk);
                g++;
            end
        end
        tx_start[idx] = 1'b1;
        din[idx]      = d;
        @(negedge clk);
        tx_start[idx] = 1'b0;
    endtask

    // Records tx on each s_tick cycle, starting with the current cycle and
    // ending with the tx_done_tick cycle.
    task automatic capture(input int idx);
        int cyc;
        cyc = 0;
        cap_q.delete();
        cap_ok = 1'b0;
        while (cyc < 3000) begin
            if (s_tick) cap_q.push_back(tx[idx]);
            if (tx_done_tick[idx]) begin
                cap_ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("capture_done_seen", cap_ok, 1'b1);
    endtask

    // Compares the captured samples with the expected frame. bits[k] is the
    // k-th bit after the start bit (data LSB first, then parity if present).
    task automatic verify(input string tag, input logic [8:0] bits, input int nb, input int sb);
        int   exp_len;
        logic lvl;
        logic act;
        logic bad;
        int   p;
        exp_len = 16 * (1 + nb) + sb;
        check({tag, "_len"}, cap_q.size(), exp_len);
        for (int k = 0; k <= nb; k++) begin
            if (k == 0) lvl = 1'b0;
            else        lvl = bits[k-1];
            bad = 1'b0;
            act = lvl;
            for (int j = 0; j < 16; j++) begin
                p = 16 * k + j;
                if (!bad && (p >= cap_q.size() || cap_q[p] !== lvl)) begin
                    bad = 1'b1;
                    act = (p < cap_q.size()) ? cap_q[p] : 1'bx;
                end
            end
            check($sformatf("%s_bit%0d", tag, k), {31'd0, act}, {31'd0, lvl});
        end
        bad = 1'b0;
        for (int j = 0; j < sb; j++) begin
            p = 16 * (1 + nb) + j;
            if (p >= cap_q.size() || cap_q[p] !== 1'b1) bad = 1'b1;
        end
        check({tag, "_stop_all_high"}, bad, 1'b0);
    endtask

    // After the done cycle: idle, line high, no second done pulse.
    task automatic post_done(input string tag, input int idx);
        @(negedge clk);
        check({tag, "_ready_after"}, tx_ready[idx], 1'b1);
        check({tag, "_done_single"}, tx_done_tick[idx], 1'b0);
        check({tag, "_tx_idle"}, tx[idx], 1'b1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         idx;
        logic [7:0] d;
        logic [8:0] bits;
        int         nb;
        int         sb;
        logic       align;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic bad;
        logic tx_h;
        int   t;
        int   cyc;

        vecs[0] = '{0, 8'h55, 9'h055, 8, 16, 1'b0};
        vecs[1] = '{0, 8'h01, 9'h001, 8, 16, 1'b1};
        vecs[2] = '{1, 8'hA7, 9'h1A7, 9, 16, 1'b1};
        vecs[3] = '{2, 8'hA7, 9'h0A7, 9, 16, 1'b0};
        vecs[4] = '{1, 8'h00, 9'h000, 9, 16, 1'b0};
        vecs[5] = '{2, 8'h00, 9'h100, 9, 16, 1'b1};
        vecs[6] = '{1, 8'hFF, 9'h0FF, 9, 16, 1'b0};
        vecs[7] = '{2, 8'hFF, 9'h1FF, 9, 16, 1'b0};
        vecs[8] = '{3, 8'hFF, 9'h07F, 7, 32, 1'b1};
        vecs[9] = '{3, 8'h80, 9'h000, 7, 32, 1'b0};

        reset    = 1'b1;
        tick_en  = 1'b1;
        tx_start = 4'd0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_tx", {28'd0, tx}, 32'hF);
        check("reset_ready", {28'd0, tx_ready}, 32'hF);
        check("reset_done", {28'd0, tx_done_tick}, 32'h0);
        reset = 1'b0;

        // Idle with no stimulus for 1000 clocks
        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 4'hF || tx_ready !== 4'hF || tx_done_tick !== 4'h0) bad = 1'b1;
        end
        check("idle_1000_stable", bad, 1'b0);

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].idx, vecs[i].d, vecs[i].align);
            check($sformatf("v%0d_busy", i), tx_ready[vecs[i].idx], 1'b0);
            check($sformatf("v%0d_start_low", i), tx[vecs[i].idx], 1'b0);
            capture(vecs[i].idx);
            verify($sformatf("v%0d", i), vecs[i].bits, vecs[i].nb, vecs[i].sb);
            post_done($sformatf("v%0d", i), vecs[i].idx);
        end

        // tx_start with din=0x00 mid-frame is ignored
        send(0, 8'h55, 1'b0);
        fork
            capture(0);
            begin
                repeat (200) @(negedge clk);
                din[0]      = 8'h00;
                tx_start[0] = 1'b1;
                @(negedge clk);
                tx_start[0] = 1'b0;
            end
        join
        verify("midstart", 9'h055, 8, 16);
        post_done("midstart", 0);

        // s_tick held low freezes the FSM and the line
        send(0, 8'h3C, 1'b0);
        fork
            capture(0);
            begin
                repeat (150) @(negedge clk);
                @(posedge clk);
                #1 tick_en = 1'b0;
                @(negedge clk);
                tx_h = tx[0];
                bad  = 1'b0;
                repeat (50) begin
                    @(negedge clk);
                    if (tx[0] !== tx_h || tx_ready[0] !== 1'b0 || tx_done_tick[0] !== 1'b0) bad = 1'b1;
                end
                @(posedge clk);
                #1 tick_en = 1'b1;
            end
        join
        check("freeze_hold", bad, 1'b0);
        verify("freeze", 9'h03C, 8, 16);
        post_done("freeze", 0);

        // Back-to-back 0x12 then 0x34: start in the done cycle is ignored,
        // start on the next cycle is accepted (1-clk gap)
        send(0, 8'h12, 1'b0);
        capture(0);
        verify("b2b_a", 9'h012, 8, 16);
        tx_start[0] = 1'b1;
        din[0]      = 8'h34;
        @(negedge clk);
        check("b2b_done_cycle_ignored", tx_ready[0], 1'b1);
        check("b2b_gap_tx_high", tx[0], 1'b1);
        @(negedge clk);
        tx_start[0] = 1'b0;
        check("b2b_accept_next", tx_ready[0], 1'b0);
        check("b2b_start_low", tx[0], 1'b0);
        capture(0);
        verify("b2b_b", 9'h034, 8, 16);
        post_done("b2b_b", 0);

        // Reset during DATA bit 3 of a 0x00 frame
        send(0, 8'h00, 1'b0);
        t   = 0;
        cyc = 0;
        while (t < 72 && cyc < 1000) begin
            if (s_tick) t++;
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_bit3", t, 72);
        check("rst_pre_tx_low", tx[0], 1'b0);
        reset = 1'b1;
        #1;
        check("rst_tx_high_now", tx[0], 1'b1);
        check("rst_ready_now", tx_ready[0], 1'b1);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (tx_done_tick[0] !== 1'b0 || tx[0] !== 1'b1) bad = 1'b1;
        end
        reset = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (tx_done_tick[0] !== 1'b0 || tx[0] !== 1'b1 || tx_ready[0] !== 1'b1) bad = 1'b1;
        end
        check("rst_no_done_idle", bad, 1'b0);
        send(0, 8'hF0, 1'b0);
        capture(0);
        verify("after_rst", 9'h0F0, 8, 16);
        post_done("after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
